lut_share_arbiter: RTL and testbench
====================================

Name: lut_share_arbiter

Overview:
- Shares one registered LUT4 evaluation engine between NUM_REQ requesters.
- Holds a bank of NUM_LUTS 16-bit INIT words, loaded through a config port.
- Each accepted request returns O = INIT[sel][{A3,A2,A1,A0}] one cycle later.
- Sits between test-fabric requesters and the LUT cell model; sequences configuration against evaluation traffic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_LUTS, 4, number of INIT words in the bank (1..16).
- SEL_W, $clog2(NUM_LUTS) (min 1), width of the LUT select fields; derived, not overridden.

Ports:
- C  in  1  clock, rising edge.
- R  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  config write offered.
- cfg_ready  out  1  config write accepted this cycle (valid&ready).
- cfg_sel  in  SEL_W  INIT word index to write.
- cfg_init  in  16  INIT value.
- req_valid  in  NUM_REQ  per-requester request offered.
- req_ready  out  NUM_REQ  one-hot grant (accept) this cycle.
- req_sel  in  NUM_REQ*SEL_W  packed per-requester LUT index, requester i at [i*SEL_W +: SEL_W].
- req_a  in  NUM_REQ*4  packed per-requester inputs {A3,A2,A1,A0}, requester i at [i*4 +: 4].
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the granted requester.
- rsp_o  out  1  evaluated LUT output; qualified by |rsp_valid.
- rsp_err  out  1  selected index >= NUM_LUTS; qualified by |rsp_valid.
- busy  out  1  high when any req_valid/cfg_valid is pending or a response is in flight.

Behaviour:
- Reset (R=0, async): INIT bank all 0, rr pointer 0, cfg_turn 0, rsp_valid 0, rsp_o 0, rsp_err 0. cfg_ready and req_ready are forced 0 while R=0.
- Ready outputs are combinational from valids, pointer and cfg_turn. Accept = valid & ready. Requesters must hold valid and payload stable until accepted.
- Arbitration per cycle, one accept max (config or one requester):
  - cfg_valid & no req_valid -> cfg_ready=1.
  - cfg_valid & any req_valid -> config wins iff cfg_turn=1; otherwise a requester wins.
  - cfg_turn register: set to 1 after a requester accept while cfg_valid=1; cleared after a config accept. Strict alternation under contention; neither side starves.
  - Requester winner: first i with req_valid[i], scanning from rr pointer upward modulo NUM_REQ. After accepting requester i, pointer <= (i+1) mod NUM_REQ. Pointer is unchanged on a config accept or an idle cycle.
- Config write: INIT[cfg_sel] <= cfg_init at the accepting edge. A cfg_sel >= NUM_LUTS write is accepted and dropped.
- Evaluation, latency 1, throughput 1 per cycle:
  - Request accepted from i in cycle t -> in cycle t+1: rsp_valid = one-hot(i), rsp_o = INIT[sel][a] using INIT as of end of cycle t, rsp_err = (sel >= NUM_LUTS).
  - When rsp_err=1, rsp_o=0.
  - No accept in cycle t -> rsp_valid=0 in t+1; rsp_o and rsp_err hold their previous values.
- Write-then-read ordering: a config accepted in cycle t is visible to requests accepted in t+1 or later. Config and request can never be accepted in the same cycle.
- Reset mid-operation: an in-flight response is discarded (rsp_valid drops immediately) and the bank is cleared.

Decomposition:
- Package lut_arb_pkg:
  - LUT_K=4, INIT_W=16.
  - function sel_width(n) returning max(1,$clog2(n)).
  - typedef lut_init_t (logic [15:0]).
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, winner index.
  - Combinational only. Pointer register stays in the parent.

Test Plan:
- Write INIT[1]=16'h8000, then requester 0 with sel=1, a=4'hF -> next cycle rsp_valid=4'b0001, rsp_o=1, rsp_err=0; same request with a=4'hE -> rsp_o=0.
- All four req_valid held high for 8 cycles, pointer 0 -> grants 0,1,2,3,0,1,2,3; each rsp_valid one-hot, lagging its grant by one cycle.
- cfg_valid held with req_valid=4'b0011 -> accept order req0, cfg, req1, cfg, ...; no side waits more than 1 cycle.
- Config INIT[0]=16'h0001 accepted at cycle t, req sel=0, a=0 accepted at t+1 -> rsp_o=1 at t+2.
- Req sel=3 with NUM_LUTS=3 -> rsp_err=1, rsp_o=0; a cfg_sel=3 write leaves the bank unchanged (readback via sel 0..2).
- Assert R=0 on the cycle after an accept -> rsp_valid=0 immediately; after release, any sel reads 0 and pointer restarts at 0.

Source files
------------

// File: rtl/lut_arb_pkg.sv
// lut_arb_pkg: shared widths, types and helpers for the LUT share arbiter
package lut_arb_pkg;
  localparam int LUT_K = 4;
  localparam int INIT_W = 16;
  typedef logic [INIT_W-1:0] lut_init_t;
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // scan from farthest to nearest so the entry closest to ptr wins last
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (en && req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/lut_share_arbiter.sv
// lut_share_arbiter: one registered LUT4 engine shared between NUM_REQ requesters,
// with a config port that alternates with evaluation traffic under contention
module lut_share_arbiter
  import lut_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_LUTS = 4,
  localparam int SEL_W = sel_width(NUM_LUTS)
) (
  input  logic                       C,
  input  logic                       R,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [SEL_W-1:0]           cfg_sel,
  input  logic [INIT_W-1:0]          cfg_init,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
  input  logic [NUM_REQ*LUT_K-1:0]   req_a,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic                       rsp_o,
  output logic                       rsp_err,
  output logic                       busy
);
  localparam int IW = sel_width(NUM_REQ);
  localparam int DEPTH = 2 ** SEL_W;
  // indices that name a real INIT word; the rest read as errors and drop writes
  localparam logic [DEPTH-1:0] LIVE = DEPTH'((64'd1 << NUM_LUTS) - 64'd1);
  lut_init_t bank [DEPTH];
  logic [IW-1:0] ptr, idx;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic [LUT_K-1:0] a;
  logic cfg_turn, cfg_win;
  assign cfg_win = cfg_valid && (!(|req_valid) || cfg_turn);
  assign cfg_ready = R && cfg_win;
  assign req_ready = grant;
  assign sel = req_sel[int'(idx)*SEL_W +: SEL_W];
  assign a = req_a[int'(idx)*LUT_K +: LUT_K];
  assign busy = (|req_valid) || cfg_valid || (|rsp_valid);
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req_valid),
    .ptr(ptr),
    .en(R && !cfg_win),
    .grant(grant),
    .idx(idx)
  );
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      ptr <= '0;
      cfg_turn <= 1'b0;
      rsp_valid <= '0;
      rsp_o <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= grant;
      if (cfg_ready) begin
        cfg_turn <= 1'b0;
        if (LIVE[cfg_sel]) bank[cfg_sel] <= cfg_init;
      end
      if (|grant) begin
        ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
        if (cfg_valid) cfg_turn <= 1'b1;
        rsp_err <= !LIVE[sel];
        rsp_o <= LIVE[sel] && bank[sel][a];
      end
    end
  end
endmodule

// File: tb/tb_lut_share_arbiter.sv
// tb_lut_share_arbiter: randomized and directed checks against a behavioural model
module tb_lut_share_arbiter;
  localparam int NR = 4;
  localparam int NL = 3;
  localparam int SW = 2;
  logic C = 0;
  logic R = 1;
  logic cfg_valid = 0;
  logic cfg_ready;
  logic [SW-1:0] cfg_sel = '0;
  logic [15:0] cfg_init = '0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready, rsp_valid;
  logic [NR*SW-1:0] req_sel = '0;
  logic [NR*4-1:0] req_a = '0;
  logic rsp_o, rsp_err, busy;
  int errors = 0;
  int checks = 0;
  logic [15:0] bank [4];
  int ptr;
  bit turn;
  logic [NR-1:0] exp_req_ready, exp_rsp_valid, got_req_ready;
  logic exp_cfg_ready, got_cfg_ready, exp_o, exp_err, exp_busy, got_busy;

  always #5 C = ~C;

  lut_share_arbiter #(.NUM_REQ(NR), .NUM_LUTS(NL)) dut (
    .C(C), .R(R),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_init(cfg_init),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_a(req_a),
    .rsp_valid(rsp_valid), .rsp_o(rsp_o), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) bank[i] = '0;
    ptr = 0;
    turn = 0;
    exp_rsp_valid = '0;
    exp_o = 0;
    exp_err = 0;
  endtask

  task automatic predict();
    exp_cfg_ready = 0;
    exp_req_ready = '0;
    exp_busy = (req_valid != 0) || cfg_valid || (exp_rsp_valid != 0);
    if (R) begin
      if (cfg_valid && (req_valid == 0 || turn)) exp_cfg_ready = 1;
      else
        for (int k = 0; k < NR; k++)
          if (req_valid[(ptr + k) % NR]) begin
            exp_req_ready[(ptr + k) % NR] = 1;
            break;
          end
    end
  endtask

  // sample readies mid-cycle, advance one clock, update the model, return 1 after the edge
  task automatic tick();
    int w;
    logic [SW-1:0] s;
    logic [3:0] av;
    #2;
    predict();
    got_cfg_ready = cfg_ready;
    got_req_ready = req_ready;
    got_busy = busy;
    @(posedge C);
    w = -1;
    for (int k = 0; k < NR; k++) if (exp_req_ready[k]) w = k;
    exp_rsp_valid = '0;
    if (w >= 0) begin
      s = req_sel[w*SW +: SW];
      av = req_a[w*4 +: 4];
      exp_rsp_valid[w] = 1;
      exp_err = (s >= NL);
      exp_o = exp_err ? 1'b0 : bank[s][av];
      ptr = (w + 1) % NR;
      if (cfg_valid) turn = 1;
    end
    if (exp_cfg_ready) begin
      if (cfg_sel < NL) bank[cfg_sel] = cfg_init;
      turn = 0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    cfg_valid = 0;
    req_valid = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    R = 0;
    #1;
    model_reset();
    @(posedge C);
    #1 R = 1;
  endtask

  task automatic test_reset();
    #1 R = 0;
    cfg_valid = 1;
    req_valid = '1;
    #2;
    checks++;
    if ({cfg_ready, req_ready} !== 5'b0) begin errors++; $display("FAIL reset_ready: got %b exp 00000", {cfg_ready, req_ready}); end
    checks++;
    if ({rsp_valid, rsp_o, rsp_err} !== 6'b0) begin errors++; $display("FAIL reset_rsp: got %b exp 000000", {rsp_valid, rsp_o, rsp_err}); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b exp 1", busy); end
    clear_inputs();
    model_reset();
    @(posedge C);
    #1 R = 1;
  endtask

  task automatic test_basic();
    cfg_valid = 1; cfg_sel = 1; cfg_init = 16'h8000;
    tick();
    checks++;
    if (got_cfg_ready !== 1'b1) begin errors++; $display("FAIL basic_cfg: got %b exp 1", got_cfg_ready); end
    cfg_valid = 0; req_valid = 4'b0001; req_sel[1:0] = 2'd1; req_a[3:0] = 4'hF;
    tick();
    checks++;
    if ({rsp_valid, rsp_o, rsp_err} !== {4'b0001, 1'b1, 1'b0}) begin errors++; $display("FAIL basic_hit: got %b exp 000110", {rsp_valid, rsp_o, rsp_err}); end
    req_a[3:0] = 4'hE;
    tick();
    checks++;
    if ({rsp_valid, rsp_o, rsp_err} !== {4'b0001, 1'b0, 1'b0}) begin errors++; $display("FAIL basic_miss: got %b exp 000100", {rsp_valid, rsp_o, rsp_err}); end
    req_valid = '0;
    tick();
    checks++;
    if ({rsp_valid, rsp_o, rsp_err} !== {exp_rsp_valid, exp_o, exp_err}) begin errors++; $display("FAIL basic_idle: got %b exp %b", {rsp_valid, rsp_o, rsp_err}, {exp_rsp_valid, exp_o, exp_err}); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] g;
    do_reset();
    req_valid = '1;
    for (int i = 0; i < NR; i++) begin
      req_sel[i*SW +: SW] = SW'($urandom_range(0, 2));
      req_a[i*4 +: 4] = 4'($urandom);
    end
    for (int k = 0; k < 8; k++) begin
      g = 4'(1 << (k % 4));
      tick();
      checks++;
      if (got_req_ready !== g) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", k, got_req_ready, g); end
      checks++;
      if ({rsp_valid, rsp_o, rsp_err} !== {g, exp_o, exp_err}) begin errors++; $display("FAIL rr_rsp%0d: got %b exp %b", k, {rsp_valid, rsp_o, rsp_err}, {g, exp_o, exp_err}); end
    end
    clear_inputs();
  endtask

  task automatic test_alternation();
    logic [4:0] ord [6];
    ord = '{5'b0_0001, 5'b1_0000, 5'b0_0010, 5'b1_0000, 5'b0_0001, 5'b1_0000};
    cfg_valid = 1; cfg_sel = 2; req_valid = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      cfg_init = 16'($urandom);
      tick();
      checks++;
      if ({got_cfg_ready, got_req_ready} !== ord[k]) begin errors++; $display("FAIL alt%0d: got %b exp %b", k, {got_cfg_ready, got_req_ready}, ord[k]); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_then_read();
    cfg_valid = 1; cfg_sel = 0; cfg_init = 16'h0001;
    tick();
    cfg_valid = 0; req_valid = 4'b0100; req_sel[5:4] = 2'd0; req_a[11:8] = 4'h0;
    tick();
    checks++;
    if ({rsp_valid, rsp_o, rsp_err} !== {4'b0100, 1'b1, 1'b0}) begin errors++; $display("FAIL wtr: got %b exp 010010", {rsp_valid, rsp_o, rsp_err}); end
    clear_inputs();
  endtask

  task automatic test_err();
    cfg_valid = 1; cfg_sel = 1; cfg_init = 16'h5A5A;
    tick();
    cfg_sel = 3; cfg_init = 16'hFFFF;
    tick();
    checks++;
    if (got_cfg_ready !== 1'b1) begin errors++; $display("FAIL err_cfg_accept: got %b exp 1", got_cfg_ready); end
    cfg_valid = 0; req_valid = 4'b1000; req_sel[7:6] = 2'd3; req_a[15:12] = 4'($urandom);
    tick();
    checks++;
    if ({rsp_valid, rsp_o, rsp_err} !== {4'b1000, 1'b0, 1'b1}) begin errors++; $display("FAIL err_rsp: got %b exp 100001", {rsp_valid, rsp_o, rsp_err}); end
    for (int k = 0; k < 12; k++) begin
      req_valid = '0;
      req_valid[k % NR] = 1;
      req_sel[(k % NR)*SW +: SW] = SW'(k % 3);
      req_a[(k % NR)*4 +: 4] = 4'($urandom);
      tick();
      checks++;
      if ({rsp_valid, rsp_o, rsp_err} !== {exp_rsp_valid, exp_o, exp_err}) begin errors++; $display("FAIL err_readback%0d: got %b exp %b", k, {rsp_valid, rsp_o, rsp_err}, {exp_rsp_valid, exp_o, exp_err}); end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1;
          req_sel[i*SW +: SW] = SW'($urandom_range(0, 3));
          req_a[i*4 +: 4] = 4'($urandom);
        end
      if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_valid = 1;
        cfg_sel = SW'($urandom_range(0, 3));
        cfg_init = 16'($urandom);
      end
      tick();
      checks++;
      if ({got_cfg_ready, got_req_ready} !== {exp_cfg_ready, exp_req_ready}) begin errors++; $display("FAIL rand_ready%0d: got %b exp %b", n, {got_cfg_ready, got_req_ready}, {exp_cfg_ready, exp_req_ready}); end
      checks++;
      if (got_busy !== exp_busy) begin errors++; $display("FAIL rand_busy%0d: got %b exp %b", n, got_busy, exp_busy); end
      checks++;
      if ({rsp_valid, rsp_o, rsp_err} !== {exp_rsp_valid, exp_o, exp_err}) begin errors++; $display("FAIL rand_rsp%0d: got %b exp %b", n, {rsp_valid, rsp_o, rsp_err}, {exp_rsp_valid, exp_o, exp_err}); end
      req_valid = req_valid & ~exp_req_ready;
      if (exp_cfg_ready) cfg_valid = 0;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    cfg_valid = 1; cfg_sel = 0; cfg_init = 16'hFFFF;
    tick();
    cfg_valid = 0; req_valid = '1;
    for (int i = 0; i < NR; i++) begin
      req_sel[i*SW +: SW] = 2'd0;
      req_a[i*4 +: 4] = 4'($urandom);
    end
    tick();
    checks++;
    if (rsp_valid === 4'b0000 || rsp_o !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b/%b exp onehot/1", rsp_valid, rsp_o); end
    R = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_o, rsp_err, req_ready} !== 10'b0) begin errors++; $display("FAIL mid_drop: got %b exp 0", {rsp_valid, rsp_o, rsp_err, req_ready}); end
    model_reset();
    @(posedge C);
    #1 R = 1;
    tick();
    checks++;
    if ({got_req_ready, rsp_valid, rsp_o} !== {4'b0001, 4'b0001, 1'b0}) begin errors++; $display("FAIL mid_restart: got %b exp 000100010", {got_req_ready, rsp_valid, rsp_o}); end
    for (int s = 1; s < 3; s++) begin
      req_valid = '0;
      req_valid[s] = 1;
      req_sel[s*SW +: SW] = SW'(s);
      tick();
      checks++;
      if ({rsp_valid, rsp_o, rsp_err} !== {exp_rsp_valid, 1'b0, 1'b0}) begin errors++; $display("FAIL mid_clear%0d: got %b exp %b", s, {rsp_valid, rsp_o, rsp_err}, {exp_rsp_valid, 2'b00}); end
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    exp_req_ready = '0;
    exp_cfg_ready = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_alternation();
    test_write_then_read();
    test_err();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
